red_pitaya_asg_sweep: RTL and testbench

Frequency-sweep sequencer for one ASG channel. It drives the channel's phase-accumulator step (the {set_step, set_step_lo} word) through a programmed ramp from a start step to a stop step, one increment per dwell interval. It also emits a trigger pulse at the start of each sweep. It sits between the ASG register bank and the channel datapath, and replaces the static step registers while a sweep is active.

---
 rtl/red_pitaya_asg_sweep.sv | 143 ++++++++++++++
 tb/tb_red_pitaya_asg_sweep.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_asg_sweep.sv
// Frequency-sweep sequencer for one ASG channel: ramps the phase-accumulator
// step word from a start to a stop value, one increment per dwell interval.
module red_pitaya_asg_sweep #(
    parameter int RSZ = 14,
    parameter int DW  = 32
) (
    input  logic            dac_clk_i,
    input  logic            dac_rst_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic [RSZ+47:0] cfg_start_i,
    input  logic [RSZ+47:0] cfg_stop_i,
    input  logic [RSZ+47:0] cfg_inc_i,
    input  logic [DW-1:0]   cfg_dwell_i,
    input  logic [1:0]      cfg_mode_i,
    input  logic [15:0]     cfg_ncyc_i,
    output logic [RSZ+47:0] step_o,
    output logic            step_upd_o,
    output logic            trig_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [15:0]     sweep_cnt_o
);

    localparam int SW = RSZ + 48;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [SW-1:0] orig_r;
    logic [SW-1:0] tgt_r;
    logic [SW-1:0] inc_r;
    logic [DW-1:0] dwell_r;
    logic [DW-1:0] dwell_cnt;
    logic [1:0]    mode_r;
    logic [15:0]   ncyc_r;
    logic          up_r;

    logic [DW-1:0] dwell_load;
    logic [15:0]   cnt_next;
    logic          at_end;
    logic          last_sweep;
    logic [SW-1:0] fwd_step;
    logic [SW-1:0] rev_step;

    // One increment toward tgt, clamped at tgt; the extra bit catches carry/borrow.
    function automatic logic [SW-1:0] step_toward(input logic [SW-1:0] cur,
                                                  input logic [SW-1:0] inc,
                                                  input logic [SW-1:0] tgt,
                                                  input logic          up);
        logic [SW:0]   nxt;
        logic [SW-1:0] res;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, inc};
            res = (nxt[SW] || nxt[SW-1:0] >= tgt) ? tgt : nxt[SW-1:0];
        end else begin
            nxt = {1'b0, cur} - {1'b0, inc};
            res = (nxt[SW] || nxt[SW-1:0] <= tgt) ? tgt : nxt[SW-1:0];
        end
        return res;
    endfunction

    assign dwell_load = (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - DW'(1);
    assign cnt_next   = (sweep_cnt_o == 16'hFFFF) ? sweep_cnt_o : sweep_cnt_o + 16'd1;
    assign at_end     = (step_o == tgt_r);
    assign last_sweep = (mode_r == 2'd0) || (mode_r == 2'd3) ||
                        ((ncyc_r != 16'd0) && (cnt_next == ncyc_r));
    assign fwd_step   = step_toward(step_o, inc_r, tgt_r, up_r);
    assign rev_step   = step_toward(step_o, inc_r, orig_r, !up_r);

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state       <= IDLE;
            step_o      <= '0;
            step_upd_o  <= 1'b0;
            trig_o      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            sweep_cnt_o <= '0;
            dwell_cnt   <= '0;
            dwell_r     <= '0;
            orig_r      <= '0;
            tgt_r       <= '0;
            inc_r       <= '0;
            mode_r      <= '0;
            ncyc_r      <= '0;
            up_r        <= 1'b1;
        end else begin
            step_upd_o <= 1'b0;
            trig_o     <= 1'b0;
            done_o     <= 1'b0;
            // step_o is left untouched on abort so the channel stays phase-continuous
            if (stop_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else if (start_i) begin
                state       <= RUN;
                busy_o      <= 1'b1;
                step_o      <= cfg_start_i;
                step_upd_o  <= 1'b1;
                trig_o      <= 1'b1;
                sweep_cnt_o <= '0;
                dwell_cnt   <= dwell_load;
                dwell_r     <= dwell_load;
                orig_r      <= cfg_start_i;
                tgt_r       <= cfg_stop_i;
                inc_r       <= cfg_inc_i;
                mode_r      <= cfg_mode_i;
                ncyc_r      <= cfg_ncyc_i;
                up_r        <= (cfg_start_i <= cfg_stop_i);
            end else if (state == RUN) begin
                if (dwell_cnt != '0) begin
                    dwell_cnt <= dwell_cnt - DW'(1);
                end else begin
                    dwell_cnt <= dwell_r;
                    if (!at_end) begin
                        step_o     <= fwd_step;
                        step_upd_o <= (fwd_step != step_o);
                    end else begin
                        sweep_cnt_o <= cnt_next;
                        if (last_sweep) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else if (mode_r == 2'd1) begin
                            step_o     <= orig_r;
                            step_upd_o <= 1'b1;
                            trig_o     <= 1'b1;
                        end else begin
                            // Triangle: swap endpoints and take the first step back at once
                            orig_r     <= tgt_r;
                            tgt_r      <= orig_r;
                            up_r       <= !up_r;
                            step_o     <= rev_step;
                            step_upd_o <= (rev_step != step_o);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Self-checking bench for red_pitaya_asg_sweep: directed scenarios plus
// randomized sweeps checked against a sweep-level reference model.
module tb_red_pitaya_asg_sweep;

    localparam int RSZ  = 14;
    localparam int DW   = 32;
    localparam int SW   = RSZ + 48;
    localparam int MAXS = 256;

    logic          dac_clk_i = 1'b0;
    logic          dac_rst_i = 1'b1;
    logic          start_i   = 1'b0;
    logic          stop_i    = 1'b0;
    logic [SW-1:0] cfg_start_i = '0;
    logic [SW-1:0] cfg_stop_i  = '0;
    logic [SW-1:0] cfg_inc_i   = '0;
    logic [DW-1:0] cfg_dwell_i = '0;
    logic [1:0]    cfg_mode_i  = '0;
    logic [15:0]   cfg_ncyc_i  = '0;
    logic [SW-1:0] step_o;
    logic          step_upd_o;
    logic          trig_o;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   sweep_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [SW-1:0] val;
        bit            upd;
        bit            trig;
        bit            done;
        bit            busy;
        int            cnt;
    } slot_t;

    slot_t slots[MAXS];

    red_pitaya_asg_sweep #(.RSZ(RSZ), .DW(DW)) dut (
        .dac_clk_i   (dac_clk_i),
        .dac_rst_i   (dac_rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .cfg_start_i (cfg_start_i),
        .cfg_stop_i  (cfg_stop_i),
        .cfg_inc_i   (cfg_inc_i),
        .cfg_dwell_i (cfg_dwell_i),
        .cfg_mode_i  (cfg_mode_i),
        .cfg_ncyc_i  (cfg_ncyc_i),
        .step_o      (step_o),
        .step_upd_o  (step_upd_o),
        .trig_o      (trig_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sweep_cnt_o (sweep_cnt_o)
    );

    always #5 dac_clk_i = ~dac_clk_i;

    task automatic tick();
        @(posedge dac_clk_i);
        #1;
    endtask

    // Drives a start pulse; returns one cycle later (t = 1 after start).
    task automatic launch(input logic [SW-1:0] s, input logic [SW-1:0] p,
                          input logic [SW-1:0] inc, input logic [DW-1:0] dw,
                          input logic [1:0] m, input logic [15:0] nc);
        cfg_start_i = s;
        cfg_stop_i  = p;
        cfg_inc_i   = inc;
        cfg_dwell_i = dw;
        cfg_mode_i  = m;
        cfg_ncyc_i  = nc;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    // Number of increments needed to reach b from a (all ones = never).
    function automatic logic [63:0] span(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] inc);
        logic [63:0] diff;
        if (a == b) return 64'd0;
        if (inc == 64'd0) return '1;
        diff = (b >= a) ? b - a : a - b;
        return (diff + inc - 64'd1) / inc;
    endfunction

    function automatic logic [SW-1:0] point(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] inc, input logic [63:0] k,
                                            input logic [63:0] kend);
        logic [63:0] r;
        if (k >= kend)   r = b;
        else if (b >= a) r = a + k * inc;
        else             r = a - k * inc;
        return r[SW-1:0];
    endfunction

    function automatic int tri_val(input int j);
        case (j % 4)
            0:       return 0;
            1:       return 10;
            2:       return 20;
            default: return 10;
        endcase
    endfunction

    // Expected outputs at every step-event slot of one sweep programme.
    task automatic build_model(input logic [SW-1:0] s, input logic [SW-1:0] p,
                               input logic [SW-1:0] inc, input logic [1:0] m,
                               input logic [15:0] nc);
        logic [63:0]   a, b, i64, k, kend, tmp;
        logic [SW-1:0] prev, val;
        int            cnt;
        bit            fin;
        a = 64'(s); b = 64'(p); i64 = 64'(inc);
        kend = span(a, b, i64);
        k = 0; cnt = 0; fin = 0;
        slots[0] = '{s, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        for (int j = 1; j < MAXS; j++) begin
            prev = slots[j-1].val;
            slots[j] = '{prev, 1'b0, 1'b0, 1'b0, !fin, cnt};
            if (fin) continue;
            if (k < kend) begin
                k = k + 1;
                val = point(a, b, i64, k, kend);
                slots[j].val = val;
                slots[j].upd = (val != prev);
            end else begin
                cnt = cnt + 1;
                slots[j].cnt = cnt;
                if (m == 2'd0 || m == 2'd3 || (nc != 16'd0 && cnt == int'(nc))) begin
                    slots[j].done = 1'b1;
                    slots[j].busy = 1'b0;
                    fin = 1;
                end else if (m == 2'd1) begin
                    k = 0;
                    slots[j].val  = s;
                    slots[j].upd  = 1'b1;
                    slots[j].trig = 1'b1;
                end else begin
                    tmp = a; a = b; b = tmp;
                    kend = span(a, b, i64);
                    k = (kend > 0) ? 64'd1 : 64'd0;
                    val = point(a, b, i64, k, kend);
                    slots[j].val = val;
                    slots[j].upd = (val != prev);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge dac_clk_i);
        #1;
        n_tests++;
        if (step_o !== '0 || busy_o !== 1'b0 || step_upd_o !== 1'b0 || trig_o !== 1'b0 ||
            done_o !== 1'b0 || sweep_cnt_o !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_held: step=%0d busy=%b upd=%b trig=%b done=%b cnt=%0d, expected all zero",
                     step_o, busy_o, step_upd_o, trig_o, done_o, sweep_cnt_o);
        end
        dac_rst_i = 1'b0;
        tick();
        n_tests++;
        if (step_o !== '0 || busy_o !== 1'b0 || trig_o !== 1'b0 || sweep_cnt_o !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: step=%0d busy=%b trig=%b cnt=%0d, expected all zero",
                     step_o, busy_o, trig_o, sweep_cnt_o);
        end
    endtask

    task automatic test_reset_mid_run();
        launch(SW'(0), SW'(1000), SW'(1), DW'(1), 2'd0, 16'd0);
        repeat (3) tick();
        n_tests++;
        if (step_o !== SW'(3) || busy_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrun_pre: step=%0d busy=%b, expected 3 1", step_o, busy_o);
        end
        #2 dac_rst_i = 1'b1;
        #1;
        n_tests++;
        if (step_o !== '0 || busy_o !== 1'b0 || sweep_cnt_o !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL midrun_async: step=%0d busy=%b cnt=%0d, expected 0 0 0",
                     step_o, busy_o, sweep_cnt_o);
        end
        #2 dac_rst_i = 1'b0;
        tick();
    endtask

    task automatic test_oneshot_up();
        logic [SW-1:0] es;
        launch(SW'(100), SW'(130), SW'(10), DW'(4), 2'd0, 16'd0);
        cfg_stop_i  = SW'(500);
        cfg_start_i = SW'(7);
        cfg_inc_i   = SW'(3);
        for (int t = 1; t <= 20; t++) begin
            es = (t < 5) ? SW'(100) : (t < 9) ? SW'(110) : (t < 13) ? SW'(120) : SW'(130);
            n_tests++;
            if (step_o !== es || step_upd_o !== (t == 1 || t == 5 || t == 9 || t == 13) ||
                trig_o !== (t == 1) || done_o !== (t == 17) || busy_o !== (t < 17) ||
                sweep_cnt_o !== ((t >= 17) ? 16'd1 : 16'd0)) begin
                n_fail++;
                $display("[TB] FAIL oneshot t=%0d: step=%0d upd=%b trig=%b done=%b busy=%b cnt=%0d, expected step=%0d",
                         t, step_o, step_upd_o, trig_o, done_o, busy_o, sweep_cnt_o, es);
            end
            tick();
        end
    endtask

    task automatic test_clamp_down(input logic [DW-1:0] dw);
        logic [SW-1:0] es;
        launch(SW'(1000), SW'(975), SW'(10), dw, 2'd0, 16'd0);
        for (int t = 1; t <= 7; t++) begin
            es = (t >= 4) ? SW'(975) : SW'(1000 - 10 * (t - 1));
            n_tests++;
            if (step_o !== es || step_upd_o !== (t <= 4) || done_o !== (t == 5) ||
                busy_o !== (t < 5) || sweep_cnt_o !== ((t >= 5) ? 16'd1 : 16'd0)) begin
                n_fail++;
                $display("[TB] FAIL clamp_down dwell=%0d t=%0d: step=%0d upd=%b done=%b busy=%b cnt=%0d, expected step=%0d",
                         dw, t, step_o, step_upd_o, done_o, busy_o, sweep_cnt_o, es);
            end
            tick();
        end
    endtask

    task automatic test_sawtooth();
        logic [SW-1:0] es;
        logic [15:0]   ec;
        launch(SW'(0), SW'(20), SW'(10), DW'(2), 2'd1, 16'd3);
        for (int t = 1; t <= 22; t++) begin
            es = (t >= 19) ? SW'(20) : SW'((((t - 1) / 2) % 3) * 10);
            ec = (t >= 19) ? 16'd3 : (t >= 13) ? 16'd2 : (t >= 7) ? 16'd1 : 16'd0;
            n_tests++;
            if (step_o !== es || trig_o !== (t == 1 || t == 7 || t == 13) ||
                done_o !== (t == 19) || busy_o !== (t < 19) || sweep_cnt_o !== ec) begin
                n_fail++;
                $display("[TB] FAIL sawtooth t=%0d: step=%0d trig=%b done=%b busy=%b cnt=%0d, expected step=%0d cnt=%0d",
                         t, step_o, trig_o, done_o, busy_o, sweep_cnt_o, es, ec);
            end
            tick();
        end
    endtask

    task automatic test_triangle();
        launch(SW'(0), SW'(20), SW'(10), DW'(1), 2'd2, 16'd0);
        for (int t = 1; t <= 100; t++) begin
            n_tests++;
            if (step_o !== SW'(tri_val(t - 1)) || trig_o !== (t == 1) ||
                busy_o !== 1'b1 || done_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL triangle t=%0d: step=%0d trig=%b busy=%b done=%b, expected step=%0d",
                         t, step_o, trig_o, busy_o, done_o, tri_val(t - 1));
            end
            if (t < 100) tick();
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (busy_o !== 1'b0 || done_o !== 1'b0 || step_upd_o !== 1'b0 ||
                step_o !== SW'(tri_val(99))) begin
                n_fail++;
                $display("[TB] FAIL triangle_stop i=%0d: step=%0d busy=%b done=%b upd=%b, expected step=%0d busy=0",
                         i, step_o, busy_o, done_o, step_upd_o, tri_val(99));
            end
            tick();
        end
    endtask

    task automatic test_collisions();
        cfg_start_i = SW'(500);
        cfg_stop_i  = SW'(600);
        cfg_inc_i   = SW'(1);
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (busy_o !== 1'b0 || trig_o !== 1'b0 || step_upd_o !== 1'b0 ||
                step_o !== SW'(tri_val(99))) begin
                n_fail++;
                $display("[TB] FAIL start_stop i=%0d: step=%0d busy=%b trig=%b upd=%b, expected step=%0d idle",
                         i, step_o, busy_o, trig_o, step_upd_o, tri_val(99));
            end
            tick();
        end
        launch(SW'(0), SW'(1000), SW'(1), DW'(1), 2'd0, 16'd0);
        repeat (5) tick();
        launch(SW'(200), SW'(100), SW'(50), DW'(1), 2'd0, 16'd0);
        for (int t = 1; t <= 5; t++) begin
            n_tests++;
            if (step_o !== ((t >= 3) ? SW'(100) : SW'(250 - 50 * t)) || trig_o !== (t == 1) ||
                done_o !== (t == 4) || sweep_cnt_o !== ((t >= 4) ? 16'd1 : 16'd0)) begin
                n_fail++;
                $display("[TB] FAIL restart t=%0d: step=%0d trig=%b done=%b cnt=%0d",
                         t, step_o, trig_o, done_o, sweep_cnt_o);
            end
            tick();
        end
    endtask

    task automatic test_random_sweeps();
        for (int it = 0; it < 25; it++) begin
            logic [SW-1:0] top, base, s, p, inc;
            logic [DW-1:0] dw;
            logic [1:0]    m;
            logic [15:0]   nc;
            int            d, j;
            bit            edge_t, eu, et, ed;
            top  = '1;
            base = ($urandom_range(0, 1) == 1) ? top - SW'(200) : '0;
            s    = base + SW'($urandom_range(0, 200));
            p    = base + SW'($urandom_range(0, 200));
            case ($urandom_range(0, 3))
                0:       inc = '0;
                1:       inc = SW'({$urandom(), $urandom()});
                default: inc = SW'($urandom_range(1, 40));
            endcase
            if ($urandom_range(0, 5) == 0) p = s;
            dw = DW'($urandom_range(0, 4));
            m  = 2'($urandom_range(0, 3));
            nc = 16'($urandom_range(0, 3));
            d  = (dw == '0) ? 1 : int'(dw);
            build_model(s, p, inc, m, nc);
            launch(s, p, inc, dw, m, nc);
            for (int t = 1; t <= 120; t++) begin
                j      = (t - 1) / d;
                edge_t = ((t - 1) % d) == 0;
                eu     = edge_t && slots[j].upd;
                et     = edge_t && slots[j].trig;
                ed     = edge_t && slots[j].done;
                n_tests++;
                if (step_o !== slots[j].val || step_upd_o !== eu || trig_o !== et ||
                    done_o !== ed || busy_o !== slots[j].busy ||
                    sweep_cnt_o !== 16'(slots[j].cnt)) begin
                    n_fail++;
                    $display("[TB] FAIL random it=%0d t=%0d: step=%0h upd=%b trig=%b done=%b busy=%b cnt=%0d, expected step=%0h upd=%b trig=%b done=%b busy=%b cnt=%0d",
                             it, t, step_o, step_upd_o, trig_o, done_o, busy_o, sweep_cnt_o,
                             slots[j].val, eu, et, ed, slots[j].busy, slots[j].cnt);
                end
                cfg_start_i = SW'({$urandom(), $urandom()});
                cfg_stop_i  = SW'({$urandom(), $urandom()});
                cfg_inc_i   = SW'($urandom());
                cfg_dwell_i = DW'($urandom_range(0, 7));
                cfg_mode_i  = 2'($urandom_range(0, 3));
                cfg_ncyc_i  = 16'($urandom_range(0, 3));
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_oneshot_up();
        test_clamp_down(DW'(1));
        test_clamp_down(DW'(0));
        test_sawtooth();
        test_triangle();
        test_collisions();
        test_random_sweeps();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
